// File: rtl/scr1_tb_ahb_slave_stall.sv
// scr1_tb_ahb_slave_stall: AHB-Lite slave front-end with stall-pattern wait states and ERROR responses.
// Define SCR1_TB_AHB_STALL_RAND_EN to draw wait states from a capped LFSR instead of the stall pattern.
module scr1_tb_ahb_slave_stall #(
  parameter int SCR1_MEM_POWER_SIZE = 16,
  parameter int SCR1_AHB_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    stall_pattern_in,
  input  logic [2:0]                     hsize,
  input  logic [1:0]                     htrans,
  input  logic [SCR1_AHB_WIDTH-1:0]      haddr,
  input  logic                           hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0]      hwdata,
  output logic                           hready,
  output logic [SCR1_AHB_WIDTH-1:0]      hrdata,
  output logic                           hresp,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [SCR1_MEM_POWER_SIZE-3:0] mem_addr,
  output logic [3:0]                     mem_be,
  output logic [31:0]                    mem_wdata,
  input  logic [31:0]                    mem_rdata
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;
  logic [1:0]                     r_state;
  logic [SCR1_MEM_POWER_SIZE-1:0] r_addr;
  logic [2:0]                     r_size;
  logic                           r_write;
  logic [SCR1_AHB_WIDTH-1:0]      r_hrdata;
  logic                           w_bit;
  logic                           w_done;
  logic                           w_accept;
  logic                           w_err;
  logic [1:0]                     w_next;
  logic [3:0]                     w_be;
  logic                           w_unused_htrans0;
  assign w_unused_htrans0 = htrans[0];
`ifdef SCR1_TB_AHB_STALL_RAND_EN
  logic [15:0] r_lfsr;
  logic [1:0]  r_zeros;
  logic [31:0] w_unused_pattern;
  assign w_unused_pattern = stall_pattern_in;
  // A forced 1 after three zeros bounds every transfer to at most three wait states.
  assign w_bit = (r_zeros == 2'd3) | r_lfsr[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= 16'hACE1;
      r_zeros <= 2'd0;
    end else if (r_state == ST_DATA) begin
      r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      r_zeros <= w_bit ? 2'd0 : r_zeros + 2'd1;
    end
  end
`else
  logic [31:0] r_pattern;
  assign w_bit = r_pattern[0];
  // An all-zero pattern would stall forever, so it is promoted to zero-wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pattern <= (stall_pattern_in == 32'd0) ? 32'hFFFF_FFFF : stall_pattern_in;
    else if (r_state == ST_DATA) r_pattern <= {r_pattern[0], r_pattern[31:1]};
  end
`endif
  assign hready   = (r_state == ST_ERR1) ? 1'b0 : (r_state == ST_DATA) ? w_bit : 1'b1;
  assign hresp    = r_state[1];
  assign w_done   = (r_state == ST_DATA) & w_bit;
  assign w_accept = htrans[1] & hready;
  assign w_err    = (|haddr[SCR1_AHB_WIDTH-1:SCR1_MEM_POWER_SIZE]) | (hsize > 3'd2) |
                    ((hsize == 3'd1) & haddr[0]) | ((hsize == 3'd2) & (|haddr[1:0]));
  assign w_next   = (r_state == ST_ERR1) ? ST_ERR2 :
                    ((r_state == ST_DATA) & ~w_bit) ? ST_DATA :
                    w_accept ? (w_err ? ST_ERR1 : ST_DATA) : ST_IDLE;
  assign w_be     = (r_size == 3'd0) ? 4'b0001 << r_addr[1:0] :
                    (r_size == 3'd1) ? 4'b0011 << r_addr[1:0] : 4'b1111;
  assign mem_req   = w_done;
  assign mem_we    = w_done & r_write;
  assign mem_be    = w_done ? w_be : 4'd0;
  assign mem_addr  = r_addr[SCR1_MEM_POWER_SIZE-1:2];
  assign mem_wdata = hwdata[31:0];
  assign hrdata    = (w_done & ~r_write) ? SCR1_AHB_WIDTH'(mem_rdata) : r_hrdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_size   <= 3'd0;
      r_write  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= haddr[SCR1_MEM_POWER_SIZE-1:0];
        r_size  <= hsize;
        r_write <= hwrite;
      end
      if (w_done & ~r_write) r_hrdata <= SCR1_AHB_WIDTH'(mem_rdata);
    end
  end
endmodule

// File: tb/tb_scr1_tb_ahb_slave_stall.sv
// tb_scr1_tb_ahb_slave_stall: randomized AHB traffic checked every cycle against a transfer-level model.
module tb_scr1_tb_ahb_slave_stall;
  localparam int P = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_pattern_in = 32'hFFFF_FFFF;
  logic [2:0]  hsize = 3'd0;
  logic [1:0]  htrans = 2'd0;
  logic [31:0] haddr = 32'd0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'd0;
  logic        hready, hresp, mem_req, mem_we;
  logic [31:0] hrdata, mem_wdata, mem_rdata;
  logic [P-3:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem [256];
  int n_pass = 0;
  int n_tot = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:0]];
  scr1_tb_ahb_slave_stall #(.SCR1_MEM_POWER_SIZE(P), .SCR1_AHB_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_pattern_in(stall_pattern_in), .hsize(hsize),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hresp(hresp), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Transfer-level model: one pending OKAY transfer or an error countdown, plus a pattern bit index.
  logic [31:0] m_pat, m_addr, m_last;
  logic [2:0]  m_size;
  bit          m_pend, m_write, e_hready, e_done, m_bit;
  int          m_k, m_err;
  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    return (a < (32'd1 << P)) && ((a % (32'd1 << s)) == 0);
  endfunction
  function automatic logic [3:0] be_of(input logic [2:0] s, input logic [31:0] a);
    int lanes;
    lanes = 1 << s;
    be_of = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(a % 4) && i < int'(a % 4) + lanes) be_of[i] = 1'b1;
  endfunction
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pat  = (stall_pattern_in == 32'd0) ? 32'hFFFF_FFFF : stall_pattern_in;
      m_k    = 0;
      m_pend = 1'b0;
      m_err  = 0;
      m_last = 32'd0;
    end else begin
      if (m_pend) begin
        m_k++;
        if (e_done) begin
          m_pend = 1'b0;
          if (!m_write) m_last = mem[m_addr[9:2]];
        end
      end
      if (m_err > 0) m_err--;
      if (e_hready && htrans[1]) begin
        m_addr  = haddr;
        m_size  = hsize;
        m_write = hwrite;
        if (legal(haddr, hsize)) m_pend = 1'b1;
        else m_err = 2;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    m_bit    = m_pat[m_k % 32];
    e_hready = (m_err == 2) ? 1'b0 : m_pend ? m_bit : 1'b1;
    e_done   = m_pend && m_bit;
    chk("hready", {31'd0, hready}, {31'd0, e_hready});
    chk("hresp", {31'd0, hresp}, {31'd0, m_err > 0});
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_done});
    chk("hrdata", hrdata, (e_done && !m_write) ? mem[m_addr[9:2]] : m_last);
    if (e_done) begin
      chk("mem_we", {31'd0, mem_we}, {31'd0, m_write});
      chk("mem_addr", {18'd0, mem_addr}, {18'd0, m_addr[P-1:2]});
      chk("mem_be", {28'd0, mem_be}, {28'd0, be_of(m_size, m_addr)});
      if (m_write) chk("mem_wdata", mem_wdata, hwdata);
    end
  end
  task automatic cyc(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                     input logic w, input logic [31:0] d);
    @(posedge clk);
    #1;
    htrans = t; haddr = a; hsize = s; hwrite = w; hwdata = d;
    @(negedge clk);
  endtask
  task automatic do_reset(input logic [31:0] p);
    @(posedge clk);
    #1;
    htrans = 2'd0;
    stall_pattern_in = p;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    logic [8:0]  hr_seq;
    int n_acc, n_req;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h10] = 32'h1234_5678;
    // zero-wait word read
    do_reset(32'hFFFF_FFFF);
    chk("rst_hrdata", hrdata, 32'd0);
    cyc(2'd2, 32'h100, 3'd2, 1'b0, 32'd0);
    chk("t1_hready_a", {31'd0, hready}, 32'd1);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_be", {28'd0, mem_be}, 32'hF);
    chk("t1_addr", {18'd0, mem_addr}, 32'h40);
    chk("t1_hrdata", hrdata, 32'hDEAD_BEEF);
    // one-wait byte write
    do_reset(32'hFFFF_FFFE);
    cyc(2'd2, 32'h203, 3'd0, 1'b1, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'hA5);
    chk("t2_stall", {31'd0, hready}, 32'd0);
    chk("t2_noreq", {31'd0, mem_req}, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'hA5);
    chk("t2_req", {31'd0, mem_req}, 32'd1);
    chk("t2_we", {31'd0, mem_we}, 32'd1);
    chk("t2_be", {28'd0, mem_be}, 32'h8);
    chk("t2_addr", {18'd0, mem_addr}, 32'h80);
    chk("t2_wdata", mem_wdata, 32'hA5);
    // pipelined burst under alternating pattern
    do_reset(32'h5555_5555);
    hr_seq = 9'b110101011;
    n_acc = 0; n_req = 0; a = 32'd0;
    for (int i = 0; i < 9; i++) begin
      cyc(n_acc >= 4 ? 2'd0 : n_acc == 0 ? 2'd2 : 2'd3, a, 3'd2, 1'b0, 32'd0);
      chk("t3_hready", {31'd0, hready}, {31'd0, hr_seq[i]});
      if (mem_req) n_req++;
      if (hready && n_acc < 4) begin n_acc++; a += 32'd4; end
    end
    chk("t3_reqs", n_req, 32'd4);
    // out-of-range then accept in ERR2
    do_reset(32'hFFFF_FFFF);
    cyc(2'd2, 32'h1_0000, 3'd2, 1'b0, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t4_err1_rdy", {31'd0, hready}, 32'd0);
    chk("t4_err1_resp", {31'd0, hresp}, 32'd1);
    chk("t4_err1_req", {31'd0, mem_req}, 32'd0);
    cyc(2'd2, 32'h40, 3'd2, 1'b0, 32'd0);
    chk("t4_err2_rdy", {31'd0, hready}, 32'd1);
    chk("t4_err2_resp", {31'd0, hresp}, 32'd1);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t4_ok_resp", {31'd0, hresp}, 32'd0);
    chk("t4_ok_req", {31'd0, mem_req}, 32'd1);
    chk("t4_ok_data", hrdata, 32'h1234_5678);
    // misaligned half, zero pattern promoted to zero-wait
    do_reset(32'd0);
    cyc(2'd2, 32'h101, 3'd1, 1'b0, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t5_err1_resp", {31'd0, hresp}, 32'd1);
    chk("t5_err1_rdy", {31'd0, hready}, 32'd0);
    cyc(2'd2, 32'h104, 3'd2, 1'b0, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t5_zero_wait", {31'd0, mem_req}, 32'd1);
    // reset during a stalled data phase
    do_reset(32'hFFFF_FFFE);
    cyc(2'd2, 32'h8, 3'd2, 1'b0, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t6_stall", {31'd0, hready}, 32'd0);
    #2;
    stall_pattern_in = 32'h3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rdy", {31'd0, hready}, 32'd1);
    chk("t6_async_req", {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2'd2, 32'h8, 3'd2, 1'b0, 32'd0);
    cyc(2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    chk("t6_new_pat", {31'd0, mem_req}, 32'd1);
    // randomized traffic
    for (int r = 0; r < 5; r++) begin
      do_reset(r == 0 ? 32'h5555_5555 : r == 1 ? 32'd0 : r == 2 ? 32'hFFFF_FFFF : $urandom);
      repeat (300) begin
        s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF);
        if ($urandom_range(0, 7) != 0 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
        cyc(2'($urandom_range(0, 3)), a, s, 1'($urandom_range(0, 1)), $urandom);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
